lut_layer_sequencer: RTL and testbench
======================================

Name: lut_layer_sequencer

Overview:
- Time-multiplexed evaluator for one LogicNets layer. One shared truth-table lookup datapath (FANIN x BW address bits -> BW-bit output) is applied to NUM_NEURONS neurons in turn.
- Truth tables and neuron input connectivity are loaded at run time through a config port.
- Sits between the registered input-feature stage and the next layer. Valid/ready handshakes on both sides.

Parameters:
- NUM_IN_FEAT, 16, number of BW-bit input features per frame.
- NUM_NEURONS, 32, neurons evaluated per frame.
- FANIN, 3, features per neuron.
- BW, 2, bits per feature and per neuron output.
- Derived: AW = FANIN*BW = 6 (truth-table address width); NW = clog2(NUM_NEURONS); FW = clog2(NUM_IN_FEAT).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input frame valid
- in_ready  out  1  sequencer accepts frame
- in_data  in  NUM_IN_FEAT*BW  features; feature f = in_data[f*BW +: BW]
- out_valid  out  1  result frame valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_NEURONS*BW  neuron n result = out_data[n*BW +: BW]
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = truth-table entry, 1 = connectivity slot
- cfg_neuron  in  NW  target neuron
- cfg_addr  in  AW  table address (cfg_sel=0); slot in cfg_addr[1:0] (cfg_sel=1)
- cfg_wdata  in  8  table data in [BW-1:0], or feature index in [FW-1:0]
- busy  out  1  high in EVAL or DONE
- cfg_err  out  1  one-cycle pulse on rejected config write

Behaviour:
- Reset (async assert, sync deassert internally):
  - FSM=IDLE; out_valid=0, out_data=0, busy=0, cfg_err=0, neuron counter=0.
  - in_ready=0 while rst_n low.
  - Truth-table and connectivity memories are NOT reset; they retain contents across reset.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready = ~cfg_we. Config has priority over a frame in the same cycle.
  - On in_valid & in_ready: latch in_data into frame register, counter=0, go to EVAL.
- EVAL (one neuron per cycle, neuron n = counter):
  - Table address = {feat[conn[n][FANIN-1]], ..., feat[conn[n][0]]}, with slot 0 in address bits [BW-1:0].
  - Table output is written to out_data slot n. Other slots hold their previous values.
  - counter increments; at counter == NUM_NEURONS-1 go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_data is stable until the handshake.
  - On out_ready: out_valid=0, go to IDLE.
  - out_valid and in_ready are never high together; there is no overlap between frames.
- Latency and throughput:
  - Accept at cycle t gives out_valid high at t+NUM_NEURONS+1.
  - Best-case frame period with out_ready tied high is NUM_NEURONS+2 cycles.
- Config writes:
  - Applied only in IDLE, and take effect for any frame accepted from the next cycle on.
  - cfg_we while busy: write ignored, cfg_err=1 for that cycle.
  - cfg_sel=1 with cfg_wdata[FW-1:0] >= NUM_IN_FEAT, cfg_addr[1:0] >= FANIN, or cfg_neuron >= NUM_NEURONS: rejected with a cfg_err pulse.
  - cfg_sel=0 with cfg_neuron >= NUM_NEURONS: rejected with a cfg_err pulse.
- Reset mid-EVAL or mid-DONE: frame discarded, out_valid=0, no partial result is ever presented.
- Table memory is distributed RAM, NUM_NEURONS*2^AW entries x BW bits, with combinational read.

Test Plan:
- Reset check: hold rst_n low 3 cycles, release -> out_valid=0, busy=0, out_data=0, in_ready=1 the cycle after release.
- Functional frame:
  - Program every neuron's table as out={a[2],a[2]} (11 when address bit 2 is set, else 00), conn[n]={n%16,(n+1)%16,(n+2)%16}.
  - Send in_data with feature f = 2'b01 for even f, 2'b00 for odd f.
  - Required: out_valid exactly 33 cycles after accept; neuron n = 11 for odd n, 00 for even n.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data unchanged, in_ready=0, busy=1. Raise out_ready -> in_ready=1 next cycle.
- Config while busy: cfg_we during EVAL to neuron 5 address 0 -> cfg_err pulses one cycle, and the next frame shows neuron 5 unchanged.
- Simultaneous cfg_we and in_valid in IDLE -> in_ready=0, write applied, frame accepted the following cycle using the new table.
- Reset at EVAL counter=10, then a fresh frame -> no out_valid before that frame completes, and table contents are preserved (result identical to the functional-frame case).

Source files
------------

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer evaluator: a single truth-table lookup is
// stepped across all neurons of a frame, one neuron per clock cycle.
module lut_layer_sequencer #(
    parameter  int NUM_IN_FEAT = 16,
    parameter  int NUM_NEURONS = 32,
    parameter  int FANIN       = 3,
    parameter  int BW          = 2,
    localparam int AW          = FANIN * BW,
    localparam int NW          = $clog2(NUM_NEURONS),
    localparam int FW          = $clog2(NUM_IN_FEAT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN_FEAT*BW-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_NEURONS*BW-1:0] out_data,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [NW-1:0]             cfg_neuron,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic                      busy,
    output logic                      cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          rst_ok_q;

    logic [BW-1:0] feat_q [NUM_IN_FEAT];
    logic [BW-1:0] out_q  [NUM_NEURONS];

    // Configuration memories carry no reset so they survive a pipeline flush.
    logic [BW-1:0] tt_mem   [NUM_NEURONS][2**AW];
    logic [FW-1:0] conn_mem [NUM_NEURONS][FANIN];

    logic          neur_ok, feat_ok, slot_ok, cfg_ok, cfg_wr, accept;
    logic [AW-1:0] tt_addr;
    logic [BW-1:0] tt_rd;
    logic          unused_wdata;

    assign unused_wdata = ^cfg_wdata[7:FW];

    if (NUM_NEURONS == (1 << NW)) begin : g_neur_full
        assign neur_ok = 1'b1;
    end else begin : g_neur_part
        assign neur_ok = (cfg_neuron < NW'(NUM_NEURONS));
    end

    if (NUM_IN_FEAT == (1 << FW)) begin : g_feat_full
        assign feat_ok = 1'b1;
    end else begin : g_feat_part
        assign feat_ok = (cfg_wdata[FW-1:0] < FW'(NUM_IN_FEAT));
    end

    assign slot_ok = ({30'd0, cfg_addr[1:0]} < 32'(FANIN));
    assign cfg_ok  = cfg_sel ? (neur_ok & slot_ok & feat_ok) : neur_ok;
    assign cfg_wr  = cfg_we & rst_ok_q & (state_q == S_IDLE) & cfg_ok;
    assign cfg_err = cfg_we & rst_ok_q & ~cfg_wr;

    // A config write in the same cycle holds off the frame by one cycle.
    assign in_ready  = rst_ok_q & (state_q == S_IDLE) & ~cfg_we;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_EVAL) | (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end
            end
            S_EVAL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == NW'(NUM_NEURONS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slot 0 of the neuron's connectivity lands in the lowest address bits.
    always_comb begin
        tt_addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            tt_addr[k*BW +: BW] = feat_q[conn_mem[cnt_q][k]];
        end
    end

    assign tt_rd = tt_mem[cnt_q][tt_addr];

    always_comb begin
        out_data = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            out_data[n*BW +: BW] = out_q[n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rst_ok_q <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                out_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_ok_q <= 1'b1;
            if (state_q == S_EVAL) begin
                out_q[cnt_q] <= tt_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int f = 0; f < NUM_IN_FEAT; f++) begin
                feat_q[f] <= in_data[f*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_wr && !cfg_sel) begin
            tt_mem[cfg_neuron][cfg_addr] <= cfg_wdata[BW-1:0];
        end
        if (cfg_wr && cfg_sel) begin
            conn_mem[cfg_neuron][cfg_addr[1:0]] <= cfg_wdata[FW-1:0];
        end
    end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: table-driven frames and config
// writes, plus hand-written backpressure, busy-write and reset sequences.
module tb_lut_layer_sequencer;
    localparam int NF = 16;
    localparam int NN = 32;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            cfg_we = 1'b0;
    logic            cfg_sel = 1'b0;
    logic [NF*BW-1:0] in_data = '0;
    logic [4:0]      cfg_neuron = '0;
    logic [5:0]      cfg_addr = '0;
    logic [7:0]      cfg_wdata = '0;
    logic            in_ready, out_valid, busy, cfg_err;
    logic [NN*BW-1:0] out_data;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] din;
        logic [63:0] dout;
    } fvec_t;

    typedef struct packed {
        logic       sel;
        logic [4:0] n;
        logic [5:0] a;
        logic [7:0] d;
        logic       err;
    } cvec_t;

    fvec_t fv [6];
    cvec_t cv [5];

    lut_layer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic sel, input logic [4:0] n, input logic [5:0] a,
                          input logic [7:0] d, output logic err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_neuron = n; cfg_addr = a; cfg_wdata = d;
        #1 err = cfg_err;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic program_all();
        int errs;
        logic e;
        logic [5:0] av;
        errs = 0;
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < 64; a++) begin
                av = 6'(a);
                cfg_wr(1'b0, 5'(n), av, {6'd0, av[2], av[2]}, e);
                if (e) errs++;
            end
            cfg_wr(1'b1, 5'(n), 6'd0, 8'((n + 2) % 16), e); if (e) errs++;
            cfg_wr(1'b1, 5'(n), 6'd1, 8'((n + 1) % 16), e); if (e) errs++;
            cfg_wr(1'b1, 5'(n), 6'd2, 8'(n % 16), e);       if (e) errs++;
        end
        chk("program_err_count", 64'(errs), 64'd0);
    endtask

    // Ends at the negedge of the first cycle after the accepting edge.
    task automatic send_frame(input logic [31:0] din);
        @(negedge clk);
        in_data = din; in_valid = 1'b1;
        #1 chk("in_ready_at_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_out(output logic [63:0] d);
        d = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic e;
        logic [63:0] d;

        fv[0] = '{din: 32'h1111_1111, dout: 64'hCCCC_CCCC_CCCC_CCCC};
        fv[1] = '{din: 32'hFFFF_FFFF, dout: 64'hFFFF_FFFF_FFFF_FFFF};
        fv[2] = '{din: 32'h0000_0000, dout: 64'h0000_0000_0000_0000};
        fv[3] = '{din: 32'h4444_4444, dout: 64'h3333_3333_3333_3333};
        fv[4] = '{din: 32'hAAAA_AAAA, dout: 64'h0000_0000_0000_0000};
        fv[5] = '{din: 32'h0000_0001, dout: 64'hC000_0000_C000_0000};

        cv[0] = '{sel: 1'b1, n: 5'd5,  a: 6'd3, d: 8'd0,  err: 1'b1};
        cv[1] = '{sel: 1'b1, n: 5'd0,  a: 6'd0, d: 8'd2,  err: 1'b0};
        cv[2] = '{sel: 1'b0, n: 5'd0,  a: 6'd0, d: 8'd0,  err: 1'b0};
        cv[3] = '{sel: 1'b1, n: 5'd31, a: 6'd3, d: 8'd7,  err: 1'b1};
        cv[4] = '{sel: 1'b1, n: 5'd31, a: 6'd2, d: 8'd15, err: 1'b0};

        // Power-on reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_out_data", out_data, 64'd0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_cfg_err", cfg_err, 1'b0);

        program_all();

        for (int i = 0; i < 6; i++) begin
            send_frame(fv[i].din);
            wait_out(1, lat);
            chk($sformatf("frame%0d_latency", i), 64'(lat), 64'd33);
            take_out(d);
            chk($sformatf("frame%0d_data", i), d, fv[i].dout);
            #1 chk($sformatf("frame%0d_idle_ready", i), in_ready, 1'b1);
        end

        // Backpressure in DONE, with a rejected write landing there too
        send_frame(32'h4444_4444);
        wait_out(1, lat);
        chk("bp_latency", 64'(lat), 64'd33);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 5'd5; cfg_addr = 6'd0; cfg_wdata = 8'h03;
                #1 chk("done_write_cfg_err", cfg_err, 1'b1);
            end
            @(negedge clk);
            cfg_we = 1'b0;
            #1;
            chk("bp_out_data", out_data, 64'h3333_3333_3333_3333);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cfg_wr(cv[i].sel, cv[i].n, cv[i].a, cv[i].d, e);
            chk($sformatf("cfgvec%0d_err", i), e, cv[i].err);
        end

        // Write during EVAL is dropped
        send_frame(32'h0000_0000);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 5'd5; cfg_addr = 6'd0; cfg_wdata = 8'h03;
        #1 chk("busy_write_cfg_err", cfg_err, 1'b1);
        @(negedge clk);
        cfg_we = 1'b0;
        #1 chk("busy_write_err_pulse_end", cfg_err, 1'b0);
        wait_out(2, lat);
        chk("busy_write_latency", 64'(lat), 64'd33);
        take_out(d);
        chk("busy_write_frame_data", d, 64'd0);

        // Write and frame together: write wins, frame follows with new table
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 5'd5; cfg_addr = 6'd4; cfg_wdata = 8'h02;
        in_data = 32'h1111_1111; in_valid = 1'b1;
        #1;
        chk("simul_in_ready", in_ready, 1'b0);
        chk("simul_cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
        #1 chk("simul_in_ready_next", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(1, lat);
        chk("simul_latency", 64'(lat), 64'd33);
        take_out(d);
        chk("simul_frame_data", d, 64'hCCCC_CCCC_CCCC_C8CC);
        cfg_wr(1'b0, 5'd5, 6'd4, 8'h03, e);
        chk("restore_cfg_err", e, 1'b0);

        // Reset while counter is 10
        send_frame(32'h1111_1111);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_data", out_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_release_in_ready", in_ready, 1'b1);
        chk("midrst_release_out_valid", out_valid, 1'b0);
        send_frame(32'h1111_1111);
        wait_out(1, lat);
        chk("midrst_latency", 64'(lat), 64'd33);
        take_out(d);
        chk("midrst_frame_data", d, 64'hCCCC_CCCC_CCCC_CCCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
